// File: rtl/bitmap_scan_reader.sv
// Raster scanner for a 1-bpp double-buffered framebuffer.
// It generates display timing, fetches one word per WORD_W pixels from a
// synchronous RAM and shifts each word out MSB-first as the pixel colour.
// The timing outputs are delayed so that they stay aligned with the colour.
module bitmap_scan_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              buf_sel,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              color,
    output logic              blank_n,
    output logic              hs,
    output logic              vs,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0]   HC_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]   HC_ACT  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]   HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]   HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0]   HC_WORD = HC_W'(WORD_W);
    localparam logic [VC_W-1:0]   VC_LAST = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]   VC_ACT  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]   VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]   VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(H_ACTIVE / WORD_W);

    // Scan state
    logic [HC_W-1:0]   hc_q, hc_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [ADDR_W-1:0] lb_q, lb_d;
    logic              buf_q, buf_d;

    // Stage 0 decode
    logic              active0, hs0, vs0, fs0, fetch0;
    logic [HC_W-1:0]   word_idx;
    logic [ADDR_W:0]   mem_addr_d;

    // Stage 1 / stage 2 registers; vld_pipe_q[0] is active at stage 1,
    // vld_pipe_q[1] is blank_n at stage 2.
    logic              mem_rd_q;
    logic [ADDR_W:0]   mem_addr_q;
    logic [1:0]        vld_pipe_q;
    logic [1:0]        hs_pipe_q, vs_pipe_q, fs_pipe_q;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              color_nx;
    logic              color_q;

    // Counter, line-base and buffer-latch next state
    always_comb begin
        hc_d  = hc_q + 1'b1;
        vc_d  = vc_q;
        lb_d  = lb_q;
        buf_d = buf_q;
        if (hc_q == HC_LAST) begin
            hc_d = '0;
            if (vc_q == VC_LAST) begin
                vc_d = '0;
                lb_d = '0;
            end else begin
                vc_d = vc_q + 1'b1;
                // Accumulate the line base instead of multiplying vc.
                if (vc_q < VC_ACT) lb_d = lb_q + LB_STEP;
            end
        end
        // Buffer swap only at the top of vsync so a frame never tears.
        if (hc_q == '0 && vc_q == VS_BEG) buf_d = buf_sel;
    end

    // Stage 0: region decode and fetch request
    always_comb begin
        active0    = (hc_q < HC_ACT) && (vc_q < VC_ACT);
        hs0        = !((hc_q >= HS_BEG) && (hc_q < HS_END));
        vs0        = !((vc_q >= VS_BEG) && (vc_q < VS_END));
        fs0        = (hc_q == '0) && (vc_q == '0);
        word_idx   = hc_q / HC_WORD;
        fetch0     = active0 && ((hc_q % HC_WORD) == '0);
        mem_addr_d = mem_addr_q;
        if (fetch0) mem_addr_d = {buf_q, lb_q + ADDR_W'(word_idx)};
    end

    // Stage 1: load a fresh word on the cycle its data returns, else shift
    always_comb begin
        if (mem_rd_q) begin
            color_nx = mem_rdata[WORD_W-1];
            shreg_d  = mem_rdata << 1;
        end else begin
            color_nx = shreg_q[WORD_W-1];
            shreg_d  = shreg_q << 1;
        end
    end

    // Scan counters and latched buffer select
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hc_q  <= '0;
            vc_q  <= '0;
            lb_q  <= '0;
            buf_q <= 1'b0;
        end else begin
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            lb_q  <= lb_d;
            buf_q <= buf_d;
        end
    end

    // Fetch outputs, shifter and the 2-deep alignment pipeline
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            shreg_q    <= '0;
            vld_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            fs_pipe_q  <= '0;
            color_q    <= 1'b0;
        end else begin
            mem_rd_q   <= fetch0;
            mem_addr_q <= mem_addr_d;
            shreg_q    <= shreg_d;
            vld_pipe_q <= {vld_pipe_q[0], active0};
            hs_pipe_q  <= {hs_pipe_q[0], hs0};
            vs_pipe_q  <= {vs_pipe_q[0], vs0};
            fs_pipe_q  <= {fs_pipe_q[0], fs0};
            color_q    <= color_nx & vld_pipe_q[0];
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign color       = color_q;
    assign blank_n     = vld_pipe_q[1];
    assign hs          = hs_pipe_q[1];
    assign vs          = vs_pipe_q[1];
    assign frame_start = fs_pipe_q[1];

endmodule

// File: tb/tb_bitmap_scan_reader.sv
// Directed bench for bitmap_scan_reader on a reduced raster (80x12 totals)
// so that several whole frames fit in a short run.
module tb_bitmap_scan_reader;

    localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
    localparam int VA = 6,  VF = 2, VSY = 2, VB = 2;
    localparam int WW = 16, AW = 6;
    localparam int HT = HA + HF + HSY + HB;   // 80
    localparam int VT = VA + VF + VSY + VB;   // 12
    localparam int F  = HT * VT;              // 960 cycles per frame

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          buf_sel = 1'b0;
    logic [AW:0]   mem_addr;
    logic          mem_rd;
    logic [WW-1:0] mem_rdata;
    logic          color, blank_n, hs, vs, frame_start;
    logic          ram_ff = 1'b0;

    int total = 0;
    int bad = 0;
    int n = 0;        // clock edges since the last reset release
    int epoch = 0;    // 0 = first run, 1 = after the mid-frame reset
    int rd_cnt0 = 0;
    logic [AW:0] rd_last0 = '0;
    logic [AW:0] last_addr = '0;
    int bits [16] = '{1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1};

    bitmap_scan_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .WORD_W(WW), .ADDR_W(AW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .buf_sel(buf_sel),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .color(color), .blank_n(blank_n), .hs(hs), .vs(vs),
        .frame_start(frame_start)
    );

    always #5 Clk = ~Clk;

    // Framebuffer contents: word 0 of buffer 0 is A5C3, buffer 1 is inverted.
    function automatic logic [15:0] ram_word(input logic b, input logic [5:0] a);
        logic [15:0] w;
        w = (a == 6'd0) ? 16'hA5C3 : {2'b01, a, ~{2'b00, a}};
        return b ? ~w : w;
    endfunction

    always_comb mem_rdata = ram_ff ? 16'hFFFF : ram_word(mem_addr[AW], mem_addr[AW-1:0]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic reset_chk();
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_blank", 32'(blank_n), 32'd0);
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
    endtask

    // One clock edge, then check fetch outputs against counter state n-1
    // and pixel outputs against counter state n-2.
    task automatic step();
        int k, f, h, v;
        logic act, bexp, px;
        logic [15:0] w;
        @(posedge Clk);
        #1;
        n++;
        k = n - 1;
        f = k / F; h = k % HT; v = (k / HT) % VT;
        act  = (h < HA) && (v < VA);
        bexp = (epoch == 0) && (f == 1 || f == 2);
        chk("mem_rd", 32'(mem_rd), 32'(act && (h % WW == 0)));
        if (act && (h % WW == 0)) last_addr = {bexp, 6'(v * (HA / WW) + h / WW)};
        chk("mem_addr", 32'(mem_addr), 32'(last_addr));
        if (epoch == 0 && f == 0 && mem_rd) begin
            rd_cnt0++;
            rd_last0 = mem_addr;
        end
        if (n < 2) begin
            chk("blank_n", 32'(blank_n), 32'd0);
            chk("hs", 32'(hs), 32'd1);
            chk("vs", 32'(vs), 32'd1);
            chk("frame_start", 32'(frame_start), 32'd0);
            chk("color", 32'(color), 32'd0);
        end else begin
            k = n - 2;
            f = k / F; h = k % HT; v = (k / HT) % VT;
            act  = (h < HA) && (v < VA);
            bexp = (epoch == 0) && (f == 1 || f == 2);
            w = (epoch == 0 && f >= 2) ? 16'hFFFF : ram_word(bexp, 6'(v * (HA / WW) + h / WW));
            px = act && w[15 - (h % WW)];
            chk("blank_n", 32'(blank_n), 32'(act));
            chk("hs", 32'(hs), 32'(!(h >= HA + HF && h < HA + HF + HSY)));
            chk("vs", 32'(vs), 32'(!(v >= VA + VF && v < VA + VF + VSY)));
            chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
            chk("color", 32'(color), 32'(px));
        end
    endtask

    initial begin
        // Reset held across several edges
        repeat (3) @(posedge Clk);
        #1;
        reset_chk();
        @(negedge Clk);
        Reset = 1'b0;

        // First fetch one edge after release, first pixel two edges after
        step();
        chk("first_rd", 32'(mem_rd), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd0);
        chk("fs_early", 32'(frame_start), 32'd0);
        step();
        chk("fs_first", 32'(frame_start), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk("ser_color", 32'(color), 32'(bits[i]));
            chk("ser_blank", 32'(blank_n), 32'd1);
        end

        // Request buffer 1 mid-frame 0; it takes effect from frame 1
        while (n < 3 * HT + 20) step();
        buf_sel = 1'b1;
        while (n < F + 1) step();
        chk("rd_cnt_frame0", 32'(rd_cnt0), 32'd24);
        chk("rd_last_frame0", 32'(rd_last0), 32'd23);

        // Drop the request after frame 1 already latched it: frame 2 stays on buffer 1
        while (n < F + 9 * HT + 5) step();
        buf_sel = 1'b0;
        // All-ones RAM from frame 2 on: colour must still follow blank_n
        while (n < F + 10 * HT) step();
        ram_ff = 1'b1;
        // Run into frame 3 (buffer 0 again), stop at hc=30, vc=3
        while (n < 3 * F + 3 * HT + 30) step();

        // Asynchronous reset mid-line, checked before any clock edge
        #2 Reset = 1'b1;
        #1;
        reset_chk();
        repeat (2) @(posedge Clk);
        #1;
        reset_chk();
        @(negedge Clk);
        ram_ff = 1'b0;
        epoch = 1;
        n = 0;
        last_addr = '0;
        Reset = 1'b0;

        step();
        chk("re_first_rd", 32'(mem_rd), 32'd1);
        chk("re_first_addr", 32'(mem_addr), 32'd0);
        step();
        chk("re_fs", 32'(frame_start), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk("re_ser_color", 32'(color), 32'(bits[i]));
        end
        while (n < 200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
